// File: rtl/s_instr_encoder.sv
// RISC-V S-type store encoder with a 2-entry output queue and address tagging.
// Define S_ENC_RV64_EN to accept funct3=011 (SD) as a legal store width.
module s_instr_encoder #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  logic [1:0]        r_cnt;
  logic [31:0]       r_word0;
  logic [31:0]       r_word1;
  logic [ADDR_W-1:0] r_qa0;
  logic [ADDR_W-1:0] r_qa1;
  logic [ADDR_W-1:0] r_ctr;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic              w_legal;
  logic              w_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_slot1;
  logic [31:0]       w_enc;

  always_comb begin
    w_legal = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
`ifdef S_ENC_RV64_EN
      3'b011: w_legal = 1'b1;
`else
      3'b011: w_legal = 1'b0;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  assign w_enc = {in_imm[11:5], in_rs2, in_rs1,
                  in_funct3, in_imm[4:0], 7'b0100011};

  assign in_ready  = (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign out_word  = r_word0;
  assign out_addr  = r_qa0;
  assign err_pulse = r_err;
  assign err_count = r_err_cnt;

  assign w_acc  = in_valid & in_ready;
  assign w_push = w_acc & w_legal;
  assign w_drop = w_acc & ~w_legal;
  assign w_pop  = out_valid & out_ready;
  // Tail slot is 1 only when one entry stays resident through this edge.
  assign w_slot1 = (r_cnt == 2'd1) & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_word0   <= '0;
      r_word1   <= '0;
      r_qa0     <= BASE_ADDR;
      r_qa1     <= BASE_ADDR;
      r_ctr     <= BASE_ADDR;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_pop) begin
        r_word0 <= r_word1;
        r_qa0   <= r_qa1;
      end
      if (w_push) begin
        if (w_slot1) begin
          r_word1 <= w_enc;
          r_qa1   <= r_ctr;
        end else begin
          r_word0 <= w_enc;
          r_qa0   <= r_ctr;
        end
        r_ctr <= r_ctr + ADDR_W'(4);
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      r_err <= w_drop;
      if (w_drop && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_s_instr_encoder.sv
// Directed-vector bench for s_instr_encoder, plus a narrow-address
// instance that exercises address wrap.
module tb_s_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [11:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_out_word;
  logic [3:0]  w_out_addr;
  logic        w_err_pulse;
  logic [7:0]  w_err_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  s_instr_encoder u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  s_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_wrap (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_funct3(3'b010), .in_rs1(5'd1),
    .in_rs2(5'd2), .in_imm(12'h004),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_word(w_out_word), .out_addr(w_out_addr),
    .err_pulse(w_err_pulse), .err_count(w_err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    w_in_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic set_in(input logic [2:0] f, input logic [4:0] a,
                        input logic [4:0] b, input logic [11:0] im);
    in_funct3 = f;
    in_rs1    = a;
    in_rs2    = b;
    in_imm    = im;
    in_valid  = 1'b1;
  endtask

  task automatic push(input logic [2:0] f, input logic [4:0] a,
                      input logic [4:0] b, input logic [11:0] im);
    int n;
    set_in(f, a, b, im);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_word", out_word, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_errp", 32'(err_pulse), 32'd0);
    chk("rst_errc", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    push(3'b010, 5'b01101, 5'b00000, 12'h0FD);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", out_word, 32'h0E06AEA3);
    chk("t1_addr", out_addr, 32'h0);
    tick();
    chk("t1_empty", 32'(out_valid), 32'd0);

    do_reset();
    out_ready = 1'b1;
    push(3'b010, 5'b00111, 5'b01011, 12'h881);
    chk("t2_w0", out_word, 32'h88B3A0A3);
    chk("t2_a0", out_addr, 32'h0);
    push(3'b000, 5'd2, 5'd3, 12'hFFF);
    chk("t2_w1", out_word, 32'hFE310FA3);
    chk("t2_a1", out_addr, 32'h4);
    tick();
    chk("t2_empty", 32'(out_valid), 32'd0);

    do_reset();
    out_ready = 1'b0;
    push(3'b010, 5'b01101, 5'b00000, 12'h0FD);
    chk("t3_rdy1", 32'(in_ready), 32'd1);
    push(3'b010, 5'b00111, 5'b01011, 12'h881);
    chk("t3_full", 32'(in_ready), 32'd0);
    set_in(3'b000, 5'd2, 5'd3, 12'hFFF);
    tick();
    chk("t3_hold_w", out_word, 32'h0E06AEA3);
    chk("t3_hold_a", out_addr, 32'h0);
    chk("t3_hold_r", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t3_w1", out_word, 32'h88B3A0A3);
    chk("t3_a1", out_addr, 32'h4);
    chk("t3_rdy2", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_w2", out_word, 32'hFE310FA3);
    chk("t3_a2", out_addr, 32'h8);
    tick();
    chk("t3_empty", 32'(out_valid), 32'd0);

    do_reset();
    out_ready = 1'b1;
    push(3'b010, 5'b01101, 5'b00000, 12'h0FD);
    chk("t4_a0", out_addr, 32'h0);
    push(3'b101, 5'd1, 5'd1, 12'h001);
    chk("t4_errp", 32'(err_pulse), 32'd1);
    chk("t4_errc", 32'(err_count), 32'd1);
    chk("t4_novalid", 32'(out_valid), 32'd0);
    push(3'b010, 5'b00111, 5'b01011, 12'h881);
    chk("t4_errp_off", 32'(err_pulse), 32'd0);
    chk("t4_w1", out_word, 32'h88B3A0A3);
    chk("t4_a1", out_addr, 32'h4);
    tick();

    push(3'b011, 5'd2, 5'd3, 12'h000);
`ifdef S_ENC_RV64_EN
    chk("sd_word", out_word, 32'h00313023);
    chk("sd_addr", out_addr, 32'h8);
    chk("sd_errp", 32'(err_pulse), 32'd0);
`else
    chk("sd_errp", 32'(err_pulse), 32'd1);
    chk("sd_errc", 32'(err_count), 32'd2);
    chk("sd_novalid", 32'(out_valid), 32'd0);
`endif
    tick();

    set_in(3'b111, 5'd0, 5'd0, 12'h000);
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_errc", 32'(err_count), 32'd255);

    out_ready = 1'b0;
    push(3'b010, 5'b01101, 5'b00000, 12'h0FD);
    push(3'b010, 5'b00111, 5'b01011, 12'h881);
    chk("t6_full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_errc", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    push(3'b000, 5'd2, 5'd3, 12'hFFF);
    chk("t6_w", out_word, 32'hFE310FA3);
    chk("t6_a", out_addr, 32'h0);
    tick();

    w_in_valid = 1'b1;
    tick();
    chk("wrap_a0", 32'(w_out_addr), 32'hC);
    chk("wrap_w0", w_out_word, 32'h0020A223);
    tick();
    w_in_valid = 1'b0;
    chk("wrap_a1", 32'(w_out_addr), 32'h0);
    chk("wrap_v1", 32'(w_out_valid), 32'd1);
    tick();
    chk("wrap_empty", 32'(w_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
